sysid_probe: RTL and testbench



---
 rtl/sysid_pkg.sv | 19 +
 rtl/sysid_probe.sv | 172 +++++++++++++++++
 tb/tb_sysid_probe.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg: types and constants shared by the system-ID probe.
//   sysid_state_t : probe FSM states
//   SYSID_ADDR_*  : word addresses of the system-ID slave
//   sysid_word_t  : 32-bit Avalon data word
package sysid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LAT,
    ST_CHECK
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef logic [31:0] sysid_word_t;

endpackage

// File: rtl/sysid_probe.sv
// sysid_probe: Avalon-MM read master that reads the system-ID slave
// (ID word at address 0, build timestamp at address 1) after reset and on
// each start pulse, latches both words and checks them against build-time
// expected values. Status is sticky until the next scan overwrites it.
//
// Ports:
//   clock           in   system clock
//   reset_n         in   synchronous active-low reset
//   start           in   single-cycle rescan request (ignored while busy)
//   avm_address     out  word address: 0 = ID, 1 = timestamp
//   avm_read        out  read request
//   avm_waitrequest in   slave stall
//   avm_readdata    in   slave read data
//   id_value        out  latched ID word
//   ts_value        out  latched timestamp word
//   busy            out  scan in progress
//   done            out  at least one scan completed since reset
//   pass            out  last completed scan matched
//   timeout         out  last scan aborted on waitrequest
module sysid_probe
  import sysid_pkg::*;
#(
  parameter sysid_word_t EXPECTED_ID  = 32'd12345,
  parameter sysid_word_t EXPECTED_TS  = 32'd0,
  parameter int unsigned CHECK_TS     = 0,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  localparam int unsigned          STALL_W    = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [1:0]           LAT_LAST   = 2'(READ_LATENCY);

  sysid_state_t       r_state, w_state_nxt;
  logic               r_addr, w_addr_nxt;
  logic [STALL_W-1:0] r_stall, w_stall_nxt;
  logic [1:0]         r_lat, w_lat_nxt;
  sysid_word_t        r_id, w_id_nxt;
  sysid_word_t        r_ts, w_ts_nxt;
  logic               r_done, w_done_nxt;
  logic               r_pass, w_pass_nxt;
  logic               r_tmo, w_tmo_nxt;
  logic               r_read, w_read_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_capture;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_REQ;
      r_addr  <= SYSID_ADDR_ID;
      r_stall <= '0;
      r_lat   <= '0;
      r_id    <= '0;
      r_ts    <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_tmo   <= 1'b0;
      r_read  <= 1'b1;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_stall <= w_stall_nxt;
      r_lat   <= w_lat_nxt;
      r_id    <= w_id_nxt;
      r_ts    <= w_ts_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_tmo   <= w_tmo_nxt;
      r_read  <= w_read_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_stall_nxt = r_stall;
    w_lat_nxt   = r_lat;
    w_id_nxt    = r_id;
    w_ts_nxt    = r_ts;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_tmo_nxt   = r_tmo;
    w_capture   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_addr_nxt  = SYSID_ADDR_ID;
          w_stall_nxt = '0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            w_capture = 1'b1;
          end else begin
            w_lat_nxt   = 2'd1;
            w_state_nxt = ST_LAT;
          end
        end else if (r_stall == STALL_LAST) begin
          // This stall cycle is the TIMEOUT-th one: abort the scan.
          w_tmo_nxt   = 1'b1;
          w_pass_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall_nxt = r_stall + 1'b1;
        end
      end
      ST_LAT: begin
        if (r_lat == LAT_LAST) begin
          w_capture = 1'b1;
        end else begin
          w_lat_nxt = r_lat + 2'd1;
        end
      end
      ST_CHECK: begin
        w_pass_nxt  = (r_id == EXPECTED_ID) &&
                      ((CHECK_TS == 0) || (r_ts == EXPECTED_TS));
        w_done_nxt  = 1'b1;
        w_tmo_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Capture is shared by the zero-latency accept and the last LAT cycle.
    if (w_capture) begin
      if (r_addr == SYSID_ADDR_ID) begin
        w_id_nxt    = avm_readdata;
        w_addr_nxt  = SYSID_ADDR_TS;
        w_stall_nxt = '0;
        w_state_nxt = ST_REQ;
      end else begin
        w_ts_nxt    = avm_readdata;
        w_state_nxt = ST_CHECK;
      end
    end

    // read/busy are registered from the next state so they leave no
    // combinational path from the inputs.
    w_read_nxt = (w_state_nxt == ST_REQ);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign id_value    = r_id;
  assign ts_value    = r_ts;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_tmo;

endmodule

// File: tb/tb_sysid_probe.sv
// Bench for sysid_probe: two instances (A: zero latency, TS checked,
// TIMEOUT 4; B: latency 2, TS unchecked, TIMEOUT 5) driven by a scripted
// Avalon slave. Each scan's expected outcome is computed from its plan and
// queued; a monitor pops and compares when busy falls.
module tb_sysid_probe;

  localparam logic [31:0] EXP_ID = 32'd12345;
  localparam logic [31:0] EXP_TS = 32'd1342531096;
  localparam int unsigned STUCK  = 100;

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction
  function automatic int unsigned tmo_of(input int i);
    return (i == 0) ? 4 : 5;
  endfunction
  function automatic int unsigned chk_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  addr, rd, wreq, busy, done, pass, tmo;
  logic [31:0] rdata [2];
  logic [31:0] id_v  [2];
  logic [31:0] ts_v  [2];

  always #5 clk = ~clk;

  sysid_probe #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .CHECK_TS    (1),
    .READ_LATENCY(0),
    .TIMEOUT     (4)
  ) u_a (
    .clock(clk), .reset_n(reset_n), .start(start),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wreq[0]),
    .avm_readdata(rdata[0]), .id_value(id_v[0]), .ts_value(ts_v[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0])
  );

  sysid_probe #(
    .EXPECTED_ID (EXP_ID),
    .CHECK_TS    (0),
    .READ_LATENCY(2),
    .TIMEOUT     (5)
  ) u_b (
    .clock(clk), .reset_n(reset_n), .start(start),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wreq[1]),
    .avm_readdata(rdata[1]), .id_value(id_v[1]), .ts_value(ts_v[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1])
  );

  // ---------------- scan plans and reference model ----------------
  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        pass;
    logic        tmo;
    int unsigned cyc;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  int unsigned pl_wait [2][2];
  logic [31:0] pl_data [2][2];
  logic [31:0] m_id [2];
  logic [31:0] m_ts [2];

  // Plan one scan for instance i and queue the outcome it must produce.
  task automatic plan(input int i, input int unsigned w0, input int unsigned w1,
                      input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    int unsigned t, l;
    t = tmo_of(i);
    l = lat_of(i);
    pl_wait[i][0] = w0;
    pl_wait[i][1] = w1;
    pl_data[i][0] = d0;
    pl_data[i][1] = d1;
    e.pass = 1'b0;
    e.tmo  = 1'b1;
    if (w0 >= t) begin
      e.cyc = t;
    end else begin
      m_id[i] = d0;
      if (w1 >= t) begin
        e.cyc = w0 + 1 + l + t;
      end else begin
        m_ts[i] = d1;
        e.tmo   = 1'b0;
        e.cyc   = w0 + w1 + 2 * l + 3;
        e.pass  = (m_id[i] == EXP_ID) && (chk_of(i) == 0 || m_ts[i] == EXP_TS);
      end
    end
    e.id = m_id[i];
    e.ts = m_ts[i];
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // ---------------- scripted slave ----------------
  int unsigned s_stall [2];
  int unsigned s_pend  [2];
  logic        s_paddr [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rdata[i] = $urandom;  // garbage outside the valid data cycle
      wreq[i]  = 1'b0;
      if (!reset_n) begin
        s_stall[i] = 0;
        s_pend[i]  = 0;
      end else begin
        if (s_pend[i] == 1) begin
          rdata[i]  = pl_data[i][s_paddr[i]];
          s_pend[i] = 0;
        end else if (s_pend[i] > 1) begin
          s_pend[i] = s_pend[i] - 1;
        end
        if (!rd[i]) begin
          s_stall[i] = 0;
        end else if (s_stall[i] < pl_wait[i][addr[i]]) begin
          wreq[i]    = 1'b1;
          s_stall[i] = s_stall[i] + 1;
        end else begin
          s_stall[i] = 0;
          if (lat_of(i) == 0) begin
            rdata[i] = pl_data[i][addr[i]];
          end else begin
            s_pend[i]  = lat_of(i);
            s_paddr[i] = addr[i];
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int unsigned mon_cnt [2];
  logic        mon_prev [2];
  logic        rst_prev = 1'b0;
  logic        hang_flag = 1'b0;
  logic        end_req = 1'b0;
  logic        end_ack = 1'b0;
  exp_t        mon_e;
  int          mon_sz;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, i, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      if (!rst_prev) begin
        q0.delete();
        q1.delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          chk("rst_id", i, id_v[i], 0);
          chk("rst_ts", i, ts_v[i], 0);
          chk("rst_done", i, 32'(done[i]), 0);
          chk("rst_pass", i, 32'(pass[i]), 0);
          chk("rst_timeout", i, 32'(tmo[i]), 0);
          chk("rst_busy", i, 32'(busy[i]), 1);
          chk("rst_read", i, 32'(rd[i]), 1);
          chk("rst_addr", i, 32'(addr[i]), 0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        mon_cnt[i]  = 0;
        mon_prev[i] = 1'b0;
      end
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) begin
          mon_cnt[i] = mon_cnt[i] + 1;
        end else if (mon_prev[i]) begin
          mon_sz = (i == 0) ? q0.size() : q1.size();
          if (mon_sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_scan dut%0d: got a completed scan expected none", i);
          end else begin
            mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("id_value", i, id_v[i], mon_e.id);
            chk("ts_value", i, ts_v[i], mon_e.ts);
            chk("pass", i, 32'(pass[i]), 32'(mon_e.pass));
            chk("timeout", i, 32'(tmo[i]), 32'(mon_e.tmo));
            chk("done", i, 32'(done[i]), 1);
            chk("scan_cycles", i, mon_cnt[i], mon_e.cyc);
          end
          mon_cnt[i] = 0;
        end
        mon_prev[i] = busy[i];
      end
      if (end_req && !end_ack) begin
        chk("scan_hang", 0, 32'(hang_flag), 0);
        chk("pending_scans", 0, 32'(q0.size()), 0);
        chk("pending_scans", 1, 32'(q1.size()), 0);
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_begin();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_id[i] = '0;
      m_ts[i] = '0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic reset_end();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy != 2'b00 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy != 2'b00) hang_flag = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic plan_both(input int unsigned w0, input int unsigned w1,
                           input logic [31:0] d0, input logic [31:0] d1);
    plan(0, w0, w1, d0, d1);
    plan(1, w0, w1, d0, d1);
  endtask

  function automatic int unsigned rnd_wait();
    return ($urandom_range(0, 9) == 0) ? STUCK : $urandom_range(0, 3);
  endfunction

  function automatic logic [31:0] rnd_word(input logic [31:0] good);
    case ($urandom_range(0, 3))
      0, 1:    return good;
      2:       return good ^ 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;

    // Power-on scan with a zero-wait slave reporting the expected image.
    reset_begin();
    plan_both(0, 0, EXP_ID, EXP_TS);
    reset_end();
    wait_idle();

    // Wrong ID.
    plan_both(0, 0, EXP_ID + 32'd1, EXP_TS);
    kick();
    wait_idle();

    // Timestamp off by one: fails only where the timestamp is checked.
    plan_both(0, 0, EXP_ID, EXP_TS - 32'd1);
    kick();
    wait_idle();

    // Three waitrequest cycles on the timestamp read.
    plan_both(0, 3, EXP_ID, EXP_TS);
    kick();
    wait_idle();

    // Stuck slave on the ID read, then recovery.
    plan_both(STUCK, 0, EXP_ID + 32'd7, EXP_TS);
    kick();
    wait_idle();
    plan_both(0, 0, EXP_ID, EXP_TS);
    kick();
    wait_idle();

    // Stuck slave on the timestamp read.
    plan_both(1, STUCK, EXP_ID, 32'd99);
    kick();
    wait_idle();

    // start during a scan must not restart it.
    plan_both(2, 1, EXP_ID, EXP_TS);
    kick();
    kick();
    @(posedge clk); #1;
    kick();
    wait_idle();

    // Reset in the middle of a scan: the scan reruns from address 0.
    plan_both(3, 0, EXP_ID + 32'd2, EXP_TS);
    kick();
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_begin();
    plan_both(0, 1, EXP_ID, EXP_TS);
    reset_end();
    wait_idle();

    // Randomised scans.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        plan(i, rnd_wait(), rnd_wait(), rnd_word(EXP_ID), rnd_word(EXP_TS));
      end
      kick();
      if ($urandom_range(0, 3) == 0) kick();
      wait_idle();
    end

    end_req = 1'b1;
    for (int n = 0; n < 20 && !end_ack; n++) begin
      @(posedge clk); #1;
    end
    if (!end_ack) begin
      $display("FAIL end_handshake: got no monitor acknowledgement expected one");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
